ro_puf_eval: RTL and testbench

- Parametrised ring-oscillator PUF evaluator. Successor to the fixed 8-bit RO_PUF.
- Inputs: NUM_RO free-running oscillator signals and a challenge. The challenge selects one RO pair per response bit.
- For each pair, rising edges are counted over a fixed window and the two counts compared. Response bits are produced sequentially under a START/DONE handshake.
- Sits between the switch/LED top level and the seven-segment display driver.

---
 rtl/ro_puf_eval_if.sv | 26 ++
 rtl/ro_puf_eval.sv | 155 +++++++++++++++
 tb/tb_ro_puf_eval.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ro_puf_eval_if.sv
`timescale 1ns/1ps
// Request/response bundle of the RO PUF evaluator: challenge and oscillators in, response and status out.
interface ro_puf_eval_if #(
  parameter int NUM_RO    = 16,
  parameter int RESP_BITS = 8
);
  localparam int SEL_W = $clog2(NUM_RO);

  logic                 start;
  logic [2*SEL_W-1:0]   challenge;
  logic [NUM_RO-1:0]    ro_in;
  logic [RESP_BITS-1:0] response;
  logic                 busy;
  logic                 done;
  logic                 unstable;

  modport master (
    output start, challenge, ro_in,
    input  response, busy, done, unstable
  );

  modport slave (
    input  start, challenge, ro_in,
    output response, busy, done, unstable
  );
endinterface

// File: rtl/ro_puf_eval.sv
`timescale 1ns/1ps
// Ring-oscillator PUF evaluator: per response bit, counts rising edges of a challenge-selected RO pair.
// Build macro PUF_VOTE_EN: each bit is the majority of three passes and UNSTABLE flags split votes.
module ro_puf_eval #(
  parameter int NUM_RO    = 16,
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024
) (
  input logic          clk,
  input logic          rst,
  ro_puf_eval_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_RO);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_COMPARE, S_DONE
  } state_t;

  state_t               state, state_nx;
  logic [NUM_RO-1:0]    sync1, sync2;
  logic [2*SEL_W-1:0]   chal;
  logic [IDX_W-1:0]     idx;
  logic [SEL_W-1:0]     sel_a, sel_b, a_nx, b_nx, off;
  logic                 prev_a, prev_b, rise_a, rise_b;
  logic [CNT_W-1:0]     cnt_a, cnt_b;
  logic [WIN_W-1:0]     win;
  logic [RESP_BITS-1:0] resp;
  logic                 last_bit, last_pass, last_win, cmp;

  // Pair for the current bit; NUM_RO is a power of two, so SEL_W-bit adds wrap mod NUM_RO.
  always_comb begin : pair_sel
    off = chal[2*SEL_W-1:SEL_W];
    if (off == '0) off = SEL_W'(NUM_RO / 2);
    a_nx = chal[SEL_W-1:0] + SEL_W'(idx);
    b_nx = a_nx + off;
  end

  assign rise_a   = sync2[sel_a] & ~prev_a;
  assign rise_b   = sync2[sel_b] & ~prev_b;
  assign last_bit = (idx == IDX_W'(RESP_BITS - 1));
  assign last_win = (win == WIN_W'(WINDOW - 1));
  assign cmp      = (cnt_a > cnt_b);

`ifdef PUF_VOTE_EN
  logic [1:0] pass, ones, ones_nx;
  logic       unstable_q;

  assign ones_nx      = ones + {1'b0, cmp};
  assign last_pass    = (pass == 2'd2);
  assign bus.unstable = unstable_q;
`else
  assign last_pass    = 1'b1;
  assign bus.unstable = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: default assigned first so no branch leaves state_nx unassigned (no latch).
  always_comb begin : fsm_next
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_nx = S_CLEAR;
      S_CLEAR:        state_nx = S_COUNT;
      S_COUNT:        if (last_win) state_nx = S_COMPARE;
      S_COMPARE:      state_nx = (last_bit && last_pass) ? S_DONE : S_CLEAR;
      default:        state_nx = S_IDLE;
    endcase
  end

  assign bus.busy     = (state == S_CLEAR) || (state == S_COUNT) || (state == S_COMPARE);
  assign bus.done     = (state == S_DONE);
  assign bus.response = resp;

  // NOTE: synchroniser and edge-history flops are reset too, so an abort leaves no stale edges.
  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      chal   <= '0;
      idx    <= '0;
      sel_a  <= '0;
      sel_b  <= '0;
      prev_a <= 1'b0;
      prev_b <= 1'b0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      win    <= '0;
      resp   <= '0;
`ifdef PUF_VOTE_EN
      pass       <= '0;
      ones       <= '0;
      unstable_q <= 1'b0;
`endif
    end else begin
      sync1 <= bus.ro_in;
      sync2 <= sync1;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            chal <= bus.challenge;
            idx  <= '0;
            resp <= '0;
`ifdef PUF_VOTE_EN
            pass       <= '0;
            ones       <= '0;
            unstable_q <= 1'b0;
`endif
          end
        end
        S_CLEAR: begin
          // Seeding prev from the current level keeps a high input from counting as an edge.
          sel_a  <= a_nx;
          sel_b  <= b_nx;
          prev_a <= sync2[a_nx];
          prev_b <= sync2[b_nx];
          cnt_a  <= '0;
          cnt_b  <= '0;
          win    <= '0;
        end
        S_COUNT: begin
          prev_a <= sync2[sel_a];
          prev_b <= sync2[sel_b];
          if (rise_a && (cnt_a != '1)) cnt_a <= cnt_a + CNT_W'(1);
          if (rise_b && (cnt_b != '1)) cnt_b <= cnt_b + CNT_W'(1);
          win <= win + WIN_W'(1);
        end
        S_COMPARE: begin
`ifdef PUF_VOTE_EN
          if (last_pass) begin
            resp[idx]  <= ones_nx[1];
            unstable_q <= unstable_q | ((ones_nx != 2'd0) && (ones_nx != 2'd3));
            pass       <= '0;
            ones       <= '0;
            if (!last_bit) idx <= idx + IDX_W'(1);
          end else begin
            pass <= pass + 2'd1;
            ones <= ones_nx;
          end
`else
          resp[idx] <= cmp;
          if (!last_bit) idx <= idx + IDX_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ro_puf_eval.sv
`timescale 1ns/1ps
// Directed bench for ro_puf_eval: RO k is a square wave of period 8+2k cycles (lower index is faster).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ro_puf_eval;
  localparam int NUM_RO    = 16;
  localparam int RESP_BITS = 8;
  localparam int CNT_W     = 16;
  // Long enough that the closest compared periods (28 vs 30) always give distinct edge counts.
  localparam int WINDOW    = 1024;
`ifdef PUF_VOTE_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam int LAT = 1 + PASSES * RESP_BITS * (WINDOW + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;

  ro_puf_eval_if #(.NUM_RO(NUM_RO), .RESP_BITS(RESP_BITS)) bus ();

  ro_puf_eval #(
    .NUM_RO(NUM_RO), .RESP_BITS(RESP_BITS), .CNT_W(CNT_W), .WINDOW(WINDOW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int start_cyc = 0;
  bit tie_mode  = 1'b0;
  bit jitter    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Oscillator model; tie_mode makes RO4 an exact copy of RO3, jitter speeds RO3 up
  // for most of the second vote pass of bit 2 (pass number 7 counted from START).
  function automatic logic [NUM_RO-1:0] ro_wave(input int c, input int rel);
    logic [NUM_RO-1:0] r;
    for (int k = 0; k < NUM_RO; k++) begin
      r[k] = ((c % (8 + 2 * k)) < (4 + k));
    end
    if (tie_mode) r[4] = r[3];
    if (jitter && rel >= 7 * (WINDOW + 2) + 50 && rel <= 8 * (WINDOW + 2) - 30)
      r[3] = ((c % 8) < 4);
    return r;
  endfunction

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    bus.ro_in  <= ro_wave(cyc, cyc - start_cyc);
  end

  // Pulses START, optionally re-pulses it with another challenge inject_at cycles later,
  // then waits (bounded) for DONE and checks latency, BUSY coverage and the response.
  task automatic run_eval(input string tag, input logic [7:0] chal, input logic [7:0] exp_resp,
                          input logic exp_unst, input int inject_at, input logic [7:0] inject_chal);
    int n;
    bit busy_ok;
    bus.challenge = chal;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    start_cyc = cyc;
    check({tag, "_accept_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_accept_done"}, 32'(bus.done), 32'd0);
    n       = 1;
    busy_ok = 1'b1;
    while (!bus.done && n < LAT + 16) begin
      busy_ok &= bus.busy;
      if (inject_at > 0 && n == inject_at) begin
        bus.challenge = inject_chal;
        bus.start     = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    // n is the START-relative edge at which DONE is first sampled high.
    check({tag, "_done"},       32'(bus.done),     32'd1);
    check({tag, "_latency"},    32'(n),            32'(LAT));
    check({tag, "_busy_held"},  32'(busy_ok),      32'd1);
    check({tag, "_busy_after"}, 32'(bus.busy),     32'd0);
    check({tag, "_response"},   32'(bus.response), 32'(exp_resp));
    check({tag, "_unstable"},   32'(bus.unstable), 32'(exp_unst));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.challenge = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_response", 32'(bus.response), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_unstable", 32'(bus.unstable), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef PUF_VOTE_EN
    jitter = 1'b1;
    run_eval("vote", 8'h10, 8'hFF, 1'b1, 0, 8'h00);
    jitter = 1'b0;
`else
    // Neighbours: RO i faster than RO i+1 for every bit.
    run_eval("t1", 8'h10, 8'hFF, 1'b0, 0, 8'h00);
    repeat (5) @(negedge clk);
    check("t1_hold_done", 32'(bus.done),     32'd1);
    check("t1_hold_resp", 32'(bus.response), 32'hFF);

    // Base 15 with off 0 -> 8: bit0 is RO15 vs RO7, then RO0..6 vs RO8..14.
    run_eval("t2", 8'h0F, 8'hFE, 1'b0, 0, 8'h00);

    tie_mode = 1'b1;
    repeat (4) @(negedge clk);
    run_eval("t3", 8'h13, 8'hFE, 1'b0, 0, 8'h00);
    tie_mode = 1'b0;
    repeat (4) @(negedge clk);

    // A START with challenge 0F mid-run must not disturb the 10 evaluation.
    run_eval("t4", 8'h10, 8'hFF, 1'b0, 500, 8'h0F);

    // Reset 3000 cycles in: bits 0 and 1 are already written, bit 2 is still counting.
    bus.challenge = 8'h10;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2999) @(negedge clk);
    check("t5_partial_resp", 32'(bus.response), 32'h03);
    check("t5_partial_busy", 32'(bus.busy),     32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_response", 32'(bus.response), 32'd0);
    check("t5_rst_busy",     32'(bus.busy),     32'd0);
    check("t5_rst_done",     32'(bus.done),     32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);
    run_eval("t5_fresh", 8'h10, 8'hFF, 1'b0, 0, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
